// File: rtl/cond_branch_seq_if.sv
// Byte-wide memory port used by cond_branch_seq for target fetch,
// stack push and stack pop accesses.
interface cond_branch_seq_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cond_branch_seq.sv
// 8085 conditional JMP/CALL/RET resolver and memory sequencer.
// Define RST_VEC_EN to enable op=11 as RST n (push, jump to n*8).
module cond_branch_seq #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          cond_en,
    input  logic [2:0]    cc,
    input  logic          flg_zero,
    input  logic          flg_parity,
    input  logic          flg_sign,
    input  logic          flg_carry,
    input  logic [AW-1:0] pc_in,
    input  logic [AW-1:0] sp_in,
    cond_branch_seq_if.master mem,
    output logic          busy,
    output logic          done,
    output logic          taken,
    output logic [AW-1:0] pc_out,
    output logic          pc_load,
    output logic [AW-1:0] sp_out,
    output logic          sp_load
);
    localparam logic [1:0] OP_JMP  = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;
    localparam logic [1:0] OP_RST  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, EVAL, RD_LO, RD_HI, PUSH_HI,
        PUSH_LO, POP_LO, POP_HI, DONE
    } state_t;

    state_t        st, nxt;
    logic [1:0]    op_q;
    logic          ce_q, z_q, p_q, s_q, c_q;
    logic [2:0]    cc_q;
    logic [AW-1:0] pc_q, sp_q;
    logic [7:0]    lo_q, hi_q;

    logic          cond_hit, take, sp_chg;
    logic [AW-1:0] pc_p2, ret_addr, tgt;
    logic [AW-1:0] sp_m1, sp_m2, sp_p1, sp_p2;
    logic [AW-1:0] pc_res, sp_res;

    assign pc_p2    = pc_q + AW'(2);
    assign ret_addr = (op_q == OP_RST) ? pc_q : pc_p2;
    assign sp_m1    = sp_q - AW'(1);
    assign sp_m2    = sp_q - AW'(2);
    assign sp_p1    = sp_q + AW'(1);
    assign sp_p2    = sp_q + AW'(2);
    assign tgt      = AW'({hi_q, lo_q});

    always_comb begin
        cond_hit = 1'b0;
        unique case (cc_q)
            3'd0: cond_hit = !z_q;
            3'd1: cond_hit = z_q;
            3'd2: cond_hit = !c_q;
            3'd3: cond_hit = c_q;
            3'd4: cond_hit = !p_q;
            3'd5: cond_hit = p_q;
            3'd6: cond_hit = !s_q;
            3'd7: cond_hit = s_q;
        endcase
    end

    always_comb begin
        take = !ce_q || cond_hit;
        if (op_q == OP_RST) begin
`ifdef RST_VEC_EN
            take = 1'b1;
`else
            take = 1'b0;
`endif
        end
    end

    // Result values are only exposed during DONE; operands are frozen.
    always_comb begin
        pc_res = tgt;
        sp_res = sp_m2;
        sp_chg = 1'b0;
        case (op_q)
            OP_JMP: begin
                if (!take) pc_res = pc_p2;
            end
            OP_CALL: begin
                if (take) sp_chg = 1'b1;
                else      pc_res = pc_p2;
            end
            OP_RET: begin
                if (take) begin
                    sp_res = sp_p2;
                    sp_chg = 1'b1;
                end else begin
                    pc_res = pc_q;
                end
            end
            default: begin
`ifdef RST_VEC_EN
                pc_res = AW'({cc_q, 3'b000});
                sp_chg = 1'b1;
`else
                pc_res = pc_q;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
            ce_q <= 1'b0;
            cc_q <= '0;
            z_q  <= 1'b0;
            p_q  <= 1'b0;
            s_q  <= 1'b0;
            c_q  <= 1'b0;
            pc_q <= '0;
            sp_q <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (st == IDLE && start) begin
                op_q <= op;
                ce_q <= cond_en;
                cc_q <= cc;
                z_q  <= flg_zero;
                p_q  <= flg_parity;
                s_q  <= flg_sign;
                c_q  <= flg_carry;
                pc_q <= pc_in;
                sp_q <= sp_in;
            end
            if (mem.mem_ack) begin
                if (st == RD_LO || st == POP_LO) lo_q <= mem.mem_rdata;
                if (st == RD_HI || st == POP_HI) hi_q <= mem.mem_rdata;
            end
        end
    end

    always_comb begin
        nxt           = st;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (st)
            IDLE: if (start) nxt = EVAL;
            EVAL: begin
                if (!take)              nxt = DONE;
                else if (op_q == OP_RET) nxt = POP_LO;
                else if (op_q == OP_RST) nxt = PUSH_HI;
                else                     nxt = RD_LO;
            end
            RD_LO: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_q;
                if (mem.mem_ack) nxt = RD_HI;
            end
            RD_HI: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_q + AW'(1);
                if (mem.mem_ack)
                    nxt = (op_q == OP_CALL) ? PUSH_HI : DONE;
            end
            PUSH_HI: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = sp_m1;
                mem.mem_wdata = 8'(ret_addr >> 8);
                if (mem.mem_ack) nxt = PUSH_LO;
            end
            PUSH_LO: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = sp_m2;
                mem.mem_wdata = ret_addr[7:0];
                if (mem.mem_ack) nxt = DONE;
            end
            POP_LO: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = sp_q;
                if (mem.mem_ack) nxt = POP_HI;
            end
            POP_HI: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = sp_p1;
                if (mem.mem_ack) nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy    = (st != IDLE);
    assign done    = (st == DONE);
    assign pc_load = done;
    assign taken   = done && take;
    assign sp_load = done && sp_chg;
    assign pc_out  = done ? pc_res : '0;
    assign sp_out  = sp_load ? sp_res : '0;
endmodule
